// File: rtl/vision_pkg.sv
// Shared definitions for the vision pipeline: default frame geometry,
// coordinate widths and the camera capture FSM state encoding.
package vision_pkg;

  localparam int X_W = 10;
  localparam int Y_W = 9;

  localparam logic [X_W-1:0] DEFAULT_FRAME_WIDTH  = 10'd320;
  localparam logic [Y_W-1:0] DEFAULT_FRAME_HEIGHT = 9'd240;

  typedef enum logic [2:0] {
    SYNC    = 3'd0,
    VBLANK  = 3'd1,
    HBLANK  = 3'd2,
    BYTE_HI = 3'd3,
    BYTE_LO = 3'd4
  } capture_state_t;

endpackage

// File: rtl/camera_capture.sv
// Camera byte-stream capture: assembles RGB565 pixels from the 8-bit camera
// bus, tracks x/y coordinates and reports per-frame completion and errors.
module camera_capture
  import vision_pkg::*;
#(
  parameter logic [X_W-1:0] FRAME_WIDTH  = DEFAULT_FRAME_WIDTH,
  parameter logic [Y_W-1:0] FRAME_HEIGHT = DEFAULT_FRAME_HEIGHT
) (
  input  logic           pixel_clock_in,
  input  logic           rst_in,
  input  logic           vsync_in,
  input  logic           href_in,
  input  logic [7:0]     cam_data_in,
  output logic [X_W-1:0] frame_x_count,
  output logic [Y_W-1:0] frame_y_count,
  output logic [15:0]    pixel_data,
  output logic           pixel_valid,
  output logic           frame_done,
  output logic           frame_error
);

  capture_state_t state_r;

  logic           vsync_r;
  logic           href_r;
  logic [7:0]     data_r;
  logic [7:0]     hi_byte_r;
  logic           bad_r;
  logic           line_drop_r;

  logic           end_frame_s;
  logic [X_W-1:0] x_eff_s;
  logic           x_room_s;
  logic           y_room_s;
  logic           line_full_s;
  logic           frame_bad_s;

  // Single input register stage on all camera pins.
  always_ff @(posedge pixel_clock_in or posedge rst_in) begin
    if (rst_in) begin
      vsync_r <= 1'b0;
      href_r  <= 1'b0;
      data_r  <= 8'd0;
    end else begin
      vsync_r <= vsync_in;
      href_r  <= href_in;
      data_r  <= cam_data_in;
    end
  end

  // Frame end detection and coordinate bookkeeping helpers.
  always_comb begin
    end_frame_s = 1'b0;
    case (state_r)
      HBLANK, BYTE_HI, BYTE_LO: end_frame_s = vsync_r;
      default:                  end_frame_s = 1'b0;
    endcase
    // x lags pixel_valid by one cycle, so fold a pending increment in.
    x_eff_s     = frame_x_count + {{(X_W-1){1'b0}}, pixel_valid};
    x_room_s    = (x_eff_s < FRAME_WIDTH);
    y_room_s    = (frame_y_count < FRAME_HEIGHT);
    line_full_s = (x_eff_s == FRAME_WIDTH);
    frame_bad_s = bad_r | (frame_y_count != FRAME_HEIGHT);
  end

  // Capture FSM with registered pixel, coordinate and frame status outputs.
  always_ff @(posedge pixel_clock_in or posedge rst_in) begin
    if (rst_in) begin
      state_r       <= SYNC;
      frame_x_count <= '0;
      frame_y_count <= '0;
      pixel_data    <= 16'd0;
      pixel_valid   <= 1'b0;
      frame_done    <= 1'b0;
      frame_error   <= 1'b0;
      hi_byte_r     <= 8'd0;
      bad_r         <= 1'b0;
      line_drop_r   <= 1'b0;
    end else begin
      pixel_valid <= 1'b0;
      frame_done  <= 1'b0;
      if (end_frame_s) begin
        // vsync during active capture closes the frame; partial pixel and
        // partial line are discarded.
        state_r       <= VBLANK;
        frame_done    <= 1'b1;
        frame_error   <= frame_bad_s;
        bad_r         <= 1'b0;
        line_drop_r   <= 1'b0;
        frame_x_count <= '0;
        frame_y_count <= '0;
      end else begin
        case (state_r)
          SYNC: begin
            if (vsync_r) begin
              state_r       <= VBLANK;
              bad_r         <= 1'b0;
              line_drop_r   <= 1'b0;
              frame_x_count <= '0;
              frame_y_count <= '0;
            end
          end
          VBLANK: begin
            frame_x_count <= '0;
            frame_y_count <= '0;
            bad_r         <= 1'b0;
            line_drop_r   <= 1'b0;
            if (!vsync_r) begin
              state_r <= HBLANK;
            end
          end
          HBLANK: begin
            if (href_r) begin
              hi_byte_r   <= data_r;
              line_drop_r <= !y_room_s;
              if (!y_room_s) begin
                bad_r <= 1'b1;
              end
              state_r <= BYTE_HI;
            end
          end
          BYTE_HI: begin
            if (href_r) begin
              frame_x_count <= x_eff_s;
              state_r       <= BYTE_LO;
              if (!line_drop_r) begin
                if (x_room_s) begin
                  pixel_data  <= {hi_byte_r, data_r};
                  pixel_valid <= 1'b1;
                end else begin
                  bad_r <= 1'b1;
                end
              end
            end else begin
              // Line ended with an unpaired high byte.
              bad_r         <= 1'b1;
              frame_x_count <= '0;
              if (!line_drop_r) begin
                frame_y_count <= frame_y_count + 9'd1;
              end
              line_drop_r <= 1'b0;
              state_r     <= HBLANK;
            end
          end
          BYTE_LO: begin
            if (href_r) begin
              hi_byte_r     <= data_r;
              frame_x_count <= x_eff_s;
              state_r       <= BYTE_HI;
            end else begin
              if (!line_full_s) begin
                bad_r <= 1'b1;
              end
              frame_x_count <= '0;
              if (!line_drop_r) begin
                frame_y_count <= frame_y_count + 9'd1;
              end
              line_drop_r <= 1'b0;
              state_r     <= HBLANK;
            end
          end
          default: begin
            state_r <= SYNC;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_camera_capture.sv
// Directed bench for camera_capture using a small frame geometry so that
// whole frames run in a few thousand cycles.
module tb_camera_capture;

  localparam int W = 16;
  localparam int H = 12;
  localparam logic [9:0] TB_W = 10'd16;
  localparam logic [8:0] TB_H = 9'd12;

  logic        clk;
  logic        rst;
  logic        vsync;
  logic        href;
  logic [7:0]  data;
  logic [9:0]  frame_x_count;
  logic [8:0]  frame_y_count;
  logic [15:0] pixel_data;
  logic        pixel_valid;
  logic        frame_done;
  logic        frame_error;

  int checks   = 0;
  int failures = 0;

  logic [34:0] pix_q[$];
  int          done_cnt = 0;
  logic        last_err = 1'b0;

  camera_capture #(
    .FRAME_WIDTH (TB_W),
    .FRAME_HEIGHT(TB_H)
  ) dut (
    .pixel_clock_in(clk),
    .rst_in        (rst),
    .vsync_in      (vsync),
    .href_in       (href),
    .cam_data_in   (data),
    .frame_x_count (frame_x_count),
    .frame_y_count (frame_y_count),
    .pixel_data    (pixel_data),
    .pixel_valid   (pixel_valid),
    .frame_done    (frame_done),
    .frame_error   (frame_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every pixel strobe and frame_done pulse away from the active edge.
  always @(negedge clk) begin
    if (pixel_valid) pix_q.push_back({frame_y_count, frame_x_count, pixel_data});
    if (frame_done) begin
      done_cnt = done_cnt + 1;
      last_err = frame_error;
    end
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    href = 1'b1;
    data = b;
    tick();
  endtask

  task automatic send_line(input int nbytes, input int base);
    logic [15:0] pix;
    for (int i = 0; i < nbytes; i++) begin
      pix = 16'hA000 + 16'(base + i / 2);
      send_byte((i % 2 == 0) ? pix[15:8] : pix[7:0]);
    end
    href = 1'b0;
    data = 8'd0;
    repeat (3) tick();
  endtask

  task automatic vsync_pulse();
    vsync = 1'b1;
    href  = 1'b0;
    repeat (3) tick();
    vsync = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    int pbase;
    int dbase;
    int got_done;
    logic [34:0] rec;

    rst = 1'b1; vsync = 1'b0; href = 1'b0; data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_value("rst_x",     32'(frame_x_count), 32'd0);
    check_value("rst_y",     32'(frame_y_count), 32'd0);
    check_value("rst_data",  32'(pixel_data),    32'd0);
    check_value("rst_valid", 32'(pixel_valid),   32'd0);
    check_value("rst_done",  32'(frame_done),    32'd0);
    check_value("rst_err",   32'(frame_error),   32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full frame with pixel n = A000+n.
    vsync_pulse();
    check_value("sync_no_done", 32'(done_cnt), 32'd0);
    @(negedge clk);
    check_value("blank_xy", {13'd0, frame_y_count, frame_x_count}, 32'd0);
    tick();
    pbase = pix_q.size();
    dbase = done_cnt;
    for (int l = 0; l < H; l++) send_line(2 * W, l * W);
    @(negedge clk);
    check_value("full_y_end", 32'(frame_y_count), 32'(H));
    tick();
    vsync_pulse();
    check_value("full_done", 32'(done_cnt - dbase), 32'd1);
    check_value("full_err",  32'(last_err), 32'd0);
    check_value("full_count", 32'(pix_q.size() - pbase), 32'(W * H));
    if (pix_q.size() - pbase == W * H) begin
      for (int i = 0; i < W * H; i++) begin
        rec = pix_q[pbase + i];
        check_value("full_data", 32'(rec[15:0]), 32'(16'hA000 + 16'(i)));
        check_value("full_xy", {13'd0, rec[34:26], rec[25:16]}, 32'(((i / W) << 10) | (i % W)));
      end
    end

    // F8/1F pixel timing on first line.
    dbase = done_cnt;
    href = 1'b1; data = 8'hF8;
    tick();
    data = 8'h1F;
    tick();
    href = 1'b0; data = 8'd0;
    @(negedge clk);
    check_value("f81f_early", 32'(pixel_valid), 32'd0);
    @(negedge clk);
    check_value("f81f_valid", 32'(pixel_valid), 32'd1);
    check_value("f81f_data",  32'(pixel_data), 32'h0000F81F);
    check_value("f81f_xy", {13'd0, frame_y_count, frame_x_count}, 32'd0);
    @(negedge clk);
    check_value("f81f_line_end", {13'd0, frame_y_count, frame_x_count}, 32'h00000400);
    tick();
    vsync_pulse();
    check_value("f81f_done", 32'(done_cnt - dbase), 32'd1);
    check_value("f81f_err",  32'(last_err), 32'd1);

    // Odd byte count: last high byte unpaired.
    pbase = pix_q.size();
    dbase = done_cnt;
    send_line(2 * W + 1, 0);
    vsync_pulse();
    check_value("odd_count", 32'(pix_q.size() - pbase), 32'(W));
    if (pix_q.size() > pbase) begin
      rec = pix_q[pix_q.size() - 1];
      check_value("odd_last", 32'(rec[15:0]), 32'(16'hA000 + 16'(W - 1)));
    end
    check_value("odd_done", 32'(done_cnt - dbase), 32'd1);
    check_value("odd_err",  32'(last_err), 32'd1);

    // Overlong line: extra pixels dropped, x holds at width.
    pbase = pix_q.size();
    dbase = done_cnt;
    for (int i = 0; i < 2 * W + 20; i++) begin
      send_byte(8'(i));
      if (i == 2 * W + 12) begin
        #3;
        check_value("long_x_hold", 32'(frame_x_count), 32'(W));
      end
    end
    href = 1'b0; data = 8'd0;
    repeat (3) tick();
    vsync_pulse();
    check_value("long_count", 32'(pix_q.size() - pbase), 32'(W));
    check_value("long_done", 32'(done_cnt - dbase), 32'd1);
    check_value("long_err",  32'(last_err), 32'd1);

    // Reset mid-frame, then capture only after the next vsync.
    for (int i = 0; i < 6; i++) send_byte(8'(i));
    rst = 1'b1;
    tick();
    @(negedge clk);
    check_value("mrst_state", {11'd0, pixel_valid, frame_done, frame_error, frame_y_count, frame_x_count}, 32'd0);
    tick();
    rst = 1'b0;
    pbase = pix_q.size();
    dbase = done_cnt;
    send_line(2 * W, 0);
    send_line(2 * W, W);
    check_value("mrst_no_pix",  32'(pix_q.size() - pbase), 32'd0);
    check_value("mrst_no_done", 32'(done_cnt - dbase), 32'd0);
    vsync_pulse();
    check_value("mrst_sync_no_done", 32'(done_cnt - dbase), 32'd0);
    send_line(2 * W, 0);
    vsync_pulse();
    check_value("mrst_pix",  32'(pix_q.size() - pbase), 32'(W));
    check_value("mrst_done", 32'(done_cnt - dbase), 32'd1);

    // vsync rising mid-line at byte 10 of line 5.
    pbase = pix_q.size();
    for (int l = 0; l < 5; l++) send_line(2 * W, l * W);
    for (int i = 0; i < 10; i++) begin
      rec[15:0] = 16'hA000 + 16'(5 * W + i / 2);
      send_byte((i % 2 == 0) ? rec[15:8] : rec[7:0]);
    end
    vsync = 1'b1; data = 8'h55;
    got_done = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (frame_done) begin
        got_done = 1;
        break;
      end
    end
    check_value("mid_done", 32'(got_done), 32'd1);
    check_value("mid_err", 32'(frame_error), 32'd1);
    @(negedge clk);
    check_value("mid_xy_zero", {13'd0, frame_y_count, frame_x_count}, 32'd0);
    tick();
    href = 1'b0;
    repeat (2) tick();
    vsync = 1'b0;
    repeat (3) tick();
    check_value("mid_count", 32'(pix_q.size() - pbase), 32'(5 * W + 5));
    if (pix_q.size() > pbase) begin
      rec = pix_q[pix_q.size() - 1];
      check_value("mid_last_xy", {13'd0, rec[34:26], rec[25:16]}, 32'((5 << 10) | 4));
      check_value("mid_last_data", 32'(rec[15:0]), 32'(16'hA000 + 16'(5 * W + 4)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/camera_capture.md
CAMERA_CAPTURE -- requirements
Module: camera_capture

Interface
REQ-001 The block SHALL have parameter FRAME_WIDTH, default 10'd320, meaning the number of pixels per line.
REQ-002 The block SHALL have parameter FRAME_HEIGHT, default 9'd240, meaning the number of lines per frame.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset; all other ports are synchronous to the clock.
REQ-004 Port pixel_clock_in, input, 1 bit: camera PCLK, the only clock; all logic is on its rising edge.
REQ-005 Port rst_in, input, 1 bit: asynchronous active-high reset.
REQ-006 Port vsync_in, input, 1 bit: camera VSYNC; high means vertical blanking.
REQ-007 Port href_in, input, 1 bit: camera HREF; high means line-active byte cycle.
REQ-008 Port cam_data_in, input, 8 bits: camera byte bus; RGB565 high byte first, then low byte.
REQ-009 Port frame_x_count, output, 10 bits: x coordinate of the presented or next pixel.
REQ-010 Port frame_y_count, output, 9 bits: y coordinate of the current line.
REQ-011 Port pixel_data, output, 16 bits: assembled RGB565 pixel {hi,lo}.
REQ-012 Port pixel_valid, output, 1 bit: one-cycle strobe; pixel_data and coordinates are valid.
REQ-013 Port frame_done, output, 1 bit: one-cycle pulse at the end of each captured frame.
REQ-014 Port frame_error, output, 1 bit: frame-malformed flag, qualified by frame_done.

Function
REQ-015 vsync_in, href_in and cam_data_in SHALL each pass through exactly one input register stage before use.
REQ-016 The FSM SHALL have the states SYNC, VBLANK, HBLANK, BYTE_HI and BYTE_LO.
REQ-017 In SYNC, the FSM SHALL ignore all bytes and move to VBLANK when registered vsync is high, so capture never starts mid-frame.
REQ-018 VBLANK SHALL hold x=0, y=0 and pixel_valid=0, and SHALL move to HBLANK when vsync is low.
REQ-019 HBLANK SHALL move to BYTE_HI on the first registered href-high cycle, capturing that cycle's byte as the high byte.
REQ-020 The high byte captured in BYTE_HI SHALL be followed by the next href-high byte, taken as the low byte in BYTE_LO.
REQ-021 pixel_valid SHALL assert 2 cycles after the low byte is on the pins, with pixel_data={hi,lo}, frame_x_count equal to the pixel's index and frame_y_count equal to the line's index.
REQ-022 frame_x_count SHALL increment the cycle after each pixel_valid; between pixels it SHALL hold the next pixel's index.
REQ-023 On href falling, the block SHALL reset x to 0 and increment y only if the line delivered at least one byte.
REQ-024 On href falling with an unpaired high byte, the block SHALL discard that byte and mark the frame bad.
REQ-025 A pixel arriving when x=FRAME_WIDTH SHALL be dropped (no pixel_valid), x SHALL hold at FRAME_WIDTH, and the frame SHALL be marked bad.
REQ-026 A line arriving when y=FRAME_HEIGHT SHALL be dropped entirely, y SHALL hold at FRAME_HEIGHT, and the frame SHALL be marked bad.
REQ-027 A line whose final x is not FRAME_WIDTH SHALL mark the frame bad.
REQ-028 vsync high from HBLANK, BYTE_HI or BYTE_LO SHALL take the FSM to VBLANK, discard any partial pixel, and pulse frame_done for one cycle.
REQ-029 At the frame_done pulse, frame_error SHALL be 1 if the frame was marked bad or y is not FRAME_HEIGHT, and 0 otherwise.
REQ-030 frame_error SHALL hold its value until the next frame_done, and the internal bad mark SHALL clear on VBLANK entry.
REQ-031 vsync rising while href is high SHALL be handled as REQ-028, and the line SHALL not count toward y.
REQ-032 x=0, y=0 with pixel_valid=0 SHALL persist for at least 1 cycle before the first pixel of every frame (downstream frame-start detection).

Reset
REQ-033 While rst_in is high, the FSM SHALL be in SYNC with frame_x_count=0, frame_y_count=0, pixel_data=0, pixel_valid=0, frame_done=0, frame_error=0 and the input registers cleared.
REQ-034 Reset asserted mid-frame SHALL drop the frame with no frame_done, and capture SHALL resume only after the next vsync high.

Structure
REQ-035 Package vision_pkg SHALL hold FRAME_WIDTH/FRAME_HEIGHT defaults, the coordinate widths, and the capture FSM state enum (shared with vision_process).
REQ-036 The block SHALL be a single module with no sub-module; the coordinate counters and byte assembler are inline.

Verification
REQ-037 Reset, vsync high, then 240 lines of 640 bytes (pixel n = 16'hA000+n) -> 320x240 pixel_valid strobes with matching x/y and data; frame_done=1 and frame_error=0.
REQ-038 Bytes 8'hF8, 8'h1F on the first line -> pixel_data=16'hF81F at x=0, y=0, two cycles after the low byte.
REQ-039 One line of 641 bytes -> 320 pixels, the odd byte discarded, frame_error=1 at frame_done.
REQ-040 One line of 660 bytes -> pixels 320..329 dropped, x holds at 320, frame_error=1.
REQ-041 Reset deasserted mid-frame (vsync low, href toggling) -> no pixel_valid and no frame_done until after the next vsync high.
REQ-042 vsync rising mid-line at byte 100 of line 50 -> frame_done pulse, frame_error=1, x=y=0 next cycle.
